pluck_envelope: RTL and testbench
=================================

PLUCK_ENVELOPE -- requirements
Module: pluck_envelope

Interface
REQ-001 Parameter TICK_DIV, default 25000, gives the clk cycles per envelope tick (1 ms at 25 MHz).
REQ-002 Parameter ATTACK_INC, default 32, is the amplitude added per tick in ATTACK.
REQ-003 Parameter DECAY_TICKS, default 8, is the number of ticks per 1-LSB amplitude decrement in DECAY.
REQ-004 Port clk  input  1  is the single system clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  is the asynchronous active-low reset.
REQ-006 Port strum  input  1  is a one-cycle strum-edge pulse from the input conditioner that starts or retriggers a note.
REQ-007 Port mute  input  1  is a level signal that silences the note while high.
REQ-008 Port wave_in  input  1  is the square-wave tone from the frequency generator.
REQ-009 Port audio_out  output  1  is the registered PWM speaker drive.
REQ-010 Port level  output  8  is the current envelope amplitude.
REQ-011 Port busy  output  1  is high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, ATTACK and DECAY, held in a registered state variable.
REQ-013 The tick prescaler SHALL count 0..TICK_DIV-1 and pulse tick for one cycle at TICK_DIV-1.
REQ-014 An accepted strum SHALL clear the prescaler and the decay sub-counter.
REQ-015 Priority SHALL be mute, then strum, then tick.
REQ-016 With mute high: next state IDLE, level 0, strum ignored.
REQ-017 A strum with mute low in any state SHALL enter ATTACK on the next edge, keeping the current level (retrigger, no click to 0).
REQ-018 On each ATTACK tick: level = min(level+ATTACK_INC, 255), 9-bit add then saturate; when the result is 255, the state SHALL go to DECAY on the same edge.
REQ-019 In DECAY, a 16-bit sub-counter SHALL count ticks; at DECAY_TICKS-1 it wraps to 0 and level decrements by 1.
REQ-020 A DECAY decrement that makes level 0 SHALL move the state to IDLE on the same edge, with no underflow.
REQ-021 IDLE SHALL hold level at 0.
REQ-022 A PWM counter (8-bit, free-running, wrapping 255->0) SHALL drive audio_out, registered one cycle, as wave_in AND (pwm_cnt < level).
REQ-023 level 0 SHALL give audio_out permanently low.
REQ-024 level 255 SHALL give a duty of 255/256 of wave_in.
REQ-025 busy SHALL be combinational from state.

Reset
REQ-026 While rst_n is low, state, level, prescaler, decay sub-counter, pwm_cnt and audio_out SHALL all be 0 and busy 0.
REQ-027 Reset asserted mid-note SHALL abort immediately; after release the block waits in IDLE for a strum.
REQ-028 Release of rst_n SHALL be synchronised externally; the block needs no extra reset-release logic.

Structure
REQ-029 The state encoding (2-bit: IDLE=0, ATTACK=1, DECAY=2) and AMP_WIDTH=8 SHALL live in the shared guitar constants package.
REQ-030 The prescaler SHALL be a sub-module named tick_divider (ports clk, rst_n, clear, tick) and be reusable by the song sequencer.
REQ-031 State 3 SHALL decode as IDLE.

Verification (TICK_DIV=4, ATTACK_INC=64, DECAY_TICKS=2)
REQ-032 Attack: strum at cycle 0 -> busy at cycle 1; level steps 64, 128, 192, 255 at ticks 1-4 (every 4 cycles), then state DECAY.
REQ-033 Decay: after the peak, level drops 1 every 8 cycles and reaches 0 after 2040 cycles, then IDLE and busy 0.
REQ-034 Retrigger: strum when level=100 in DECAY -> ATTACK; next ticks give 164, 228, 255; level never reaches 0.
REQ-035 Mute and strum in the same cycle with level=200 -> level 0, IDLE next edge, audio_out 0 after 1 cycle.
REQ-036 PWM: hold level at 64 with wave_in=1 -> audio_out high exactly 64 of every 256 cycles; with wave_in=0 -> always 0.
REQ-037 Reset: drop rst_n during ATTACK -> all outputs 0 asynchronously (before next clk edge); a strum after release restarts from level 0.

Source files
------------

// File: rtl/pluck_envelope_pkg.sv
// Shared guitar constants: envelope state encoding, amplitude width and a saturating add.
// Pure definitions; no latency or backpressure.
package pluck_envelope_pkg;

  localparam int AMP_WIDTH = 8;
  localparam logic [AMP_WIDTH-1:0] AMP_MAX  = '1;
  localparam logic [AMP_WIDTH-1:0] AMP_ZERO = '0;
  localparam logic [AMP_WIDTH-1:0] AMP_ONE  = AMP_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_DECAY  = 2'd2
  } env_state_t;

  // One extra bit catches the carry so the result clamps at full scale.
  function automatic logic [AMP_WIDTH-1:0] amp_sat_add(input logic [AMP_WIDTH-1:0] a,
                                                        input logic [AMP_WIDTH:0]   inc);
    logic [AMP_WIDTH:0] sum;
    sum = {1'b0, a} + inc;
    return sum[AMP_WIDTH] ? AMP_MAX : sum[AMP_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pluck_envelope_tick_divider.sv
// Tick prescaler: counts 0..DIV-1, tick is high for the one cycle the count sits at DIV-1.
// Latency: tick is combinational from the count; no backpressure, clear restarts from 0.
module tick_divider #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pluck_envelope.sv
// Pluck envelope: strum ramps amplitude up, it decays to silence, PWM gates the tone by level.
// Latency: state/level update on the edge after strum/tick; audio_out is one cycle behind; no backpressure.
module pluck_envelope
  import pluck_envelope_pkg::*;
#(
  parameter int TICK_DIV    = 25000,
  parameter int ATTACK_INC  = 32,
  parameter int DECAY_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 strum,
  input  logic                 mute,
  input  logic                 wave_in,
  output logic                 audio_out,
  output logic [AMP_WIDTH-1:0] level,
  output logic                 busy
);

  localparam logic [AMP_WIDTH:0] INC      = (AMP_WIDTH + 1)'(ATTACK_INC);
  localparam logic [15:0]        SUB_LAST = 16'(DECAY_TICKS - 1);

  env_state_t           state, state_nxt;
  logic [AMP_WIDTH-1:0] level_nxt;
  logic [AMP_WIDTH-1:0] pwm_cnt;
  logic [15:0]          sub_cnt, sub_nxt;
  logic                 tick;
  logic                 presc_clr;

  tick_divider #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      level   <= AMP_ZERO;
      sub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      sub_cnt <= sub_nxt;
    end
  end

  // Mute beats strum beats tick; a retrigger keeps the current level to avoid a click.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    sub_nxt   = sub_cnt;
    presc_clr = 1'b0;
    if (mute) begin
      state_nxt = ST_IDLE;
      level_nxt = AMP_ZERO;
    end else if (strum) begin
      state_nxt = ST_ATTACK;
      presc_clr = 1'b1;
      sub_nxt   = '0;
    end else begin
      case (state)
        ST_ATTACK: begin
          if (tick) begin
            level_nxt = amp_sat_add(level, INC);
            if (level_nxt == AMP_MAX) state_nxt = ST_DECAY;
          end
        end
        ST_DECAY: begin
          if (tick) begin
            if (sub_cnt >= SUB_LAST) begin
              sub_nxt = '0;
              if (level <= AMP_ONE) begin
                level_nxt = AMP_ZERO;
                state_nxt = ST_IDLE;
              end else begin
                level_nxt = level - AMP_ONE;
              end
            end else begin
              sub_nxt = sub_cnt + 16'd1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          level_nxt = AMP_ZERO;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_ATTACK) || (state == ST_DECAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + AMP_ONE;
      audio_out <= wave_in & (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_pluck_envelope.sv
// Directed bench for pluck_envelope: fast instance for envelope timing, slow instance for PWM duty.
module tb_pluck_envelope;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strum = 1'b0, mute = 1'b0, wave_in = 1'b0;
  logic       audio_out, busy;
  logic [7:0] level;
  logic       p_strum = 1'b0, p_mute = 1'b0, p_wave = 1'b0;
  logic       p_audio, p_busy;
  logic [7:0] p_level;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pluck_envelope #(.TICK_DIV(4), .ATTACK_INC(64), .DECAY_TICKS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .strum(strum), .mute(mute), .wave_in(wave_in),
    .audio_out(audio_out), .level(level), .busy(busy)
  );

  pluck_envelope #(.TICK_DIV(600), .ATTACK_INC(64), .DECAY_TICKS(2)) u_pwm (
    .clk(clk), .rst_n(rst_n), .strum(p_strum), .mute(p_mute), .wave_in(p_wave),
    .audio_out(p_audio), .level(p_level), .busy(p_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strum_pulse();
    strum = 1'b1;
    step();
    strum = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (level !== 8'd0 || busy !== 1'b0 || audio_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: level=%0d busy=%b audio=%b, want 0/0/0", level, busy, audio_out);
    end
    repeat (3) step();
    rst_n = 1'b1;
    wave_in = 1'b1;
    begin
      int cnt = 0;
      repeat (256) begin
        if (audio_out) cnt++;
        step();
      end
      vectors++;
      if (cnt != 0 || busy !== 1'b0 || level !== 8'd0) begin
        miscompares++;
        $display("FAIL idle_level0_audio: high=%0d busy=%b level=%0d, want 0/0/0", cnt, busy, level);
      end
    end
  endtask

  task automatic test_attack();
    logic [7:0] exp_lv [4];
    exp_lv = '{8'd64, 8'd128, 8'd192, 8'd255};
    strum_pulse();
    vectors++;
    if (busy !== 1'b1 || level !== 8'd0) begin
      miscompares++;
      $display("FAIL attack_busy: busy=%b level=%0d, want 1/0", busy, level);
    end
    for (int k = 0; k < 4; k++) begin
      repeat (3) step();
      vectors++;
      if (level !== (k == 0 ? 8'd0 : exp_lv[k-1])) begin
        miscompares++;
        $display("FAIL attack_hold%0d: level=%0d", k, level);
      end
      step();
      vectors++;
      if (level !== exp_lv[k]) begin
        miscompares++;
        $display("FAIL attack_tick%0d: level=%0d, want %0d", k + 1, level, exp_lv[k]);
      end
    end
    vectors++;
    if (u_dut.state !== 2'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL attack_to_decay: state=%0d busy=%b, want 2/1", u_dut.state, busy);
    end
  endtask

  task automatic test_decay();
    repeat (7) step();
    vectors++;
    if (level !== 8'd255) begin
      miscompares++;
      $display("FAIL decay_hold: level=%0d, want 255", level);
    end
    step();
    vectors++;
    if (level !== 8'd254) begin
      miscompares++;
      $display("FAIL decay_first: level=%0d, want 254", level);
    end
    repeat (2031) step();
    vectors++;
    if (level !== 8'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL decay_last: level=%0d busy=%b, want 1/1", level, busy);
    end
    step();
    vectors++;
    if (level !== 8'd0 || busy !== 1'b0 || u_dut.state !== 2'd0) begin
      miscompares++;
      $display("FAIL decay_end: level=%0d busy=%b state=%0d, want 0/0/0", level, busy, u_dut.state);
    end
  endtask

  task automatic wait_level(input logic [7:0] tgt);
    bit found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (level === tgt) found = 1'b1;
      else step();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL wait_level: level=%0d never reached %0d", level, tgt);
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] exp_lv [3];
    bit hit_zero = 1'b0;
    exp_lv = '{8'd164, 8'd228, 8'd255};
    strum_pulse();
    wait_level(8'd100);
    strum_pulse();
    vectors++;
    if (level !== 8'd100 || u_dut.state !== 2'd1) begin
      miscompares++;
      $display("FAIL retrig_enter: level=%0d state=%0d, want 100/1", level, u_dut.state);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin
        step();
        if (level === 8'd0) hit_zero = 1'b1;
      end
      vectors++;
      if (level !== exp_lv[k]) begin
        miscompares++;
        $display("FAIL retrig_tick%0d: level=%0d, want %0d", k + 1, level, exp_lv[k]);
      end
    end
    vectors++;
    if (hit_zero || u_dut.state !== 2'd2) begin
      miscompares++;
      $display("FAIL retrig_nozero: hit_zero=%b state=%0d, want 0/2", hit_zero, u_dut.state);
    end
  endtask

  task automatic test_mute();
    wait_level(8'd200);
    wait_level(8'd0);
    strum_pulse();
    wait_level(8'd200);
    strum = 1'b1;
    mute = 1'b1;
    step();
    vectors++;
    if (level !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mute_level: level=%0d busy=%b, want 0/0", level, busy);
    end
    step();
    vectors++;
    if (audio_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mute_audio: audio=%b busy=%b, want 0/0", audio_out, busy);
    end
    repeat (8) step();
    vectors++;
    if (busy !== 1'b0 || level !== 8'd0) begin
      miscompares++;
      $display("FAIL mute_hold: busy=%b level=%0d, want 0/0", busy, level);
    end
    strum = 1'b0;
    mute = 1'b0;
    step();
  endtask

  task automatic count_pwm(input int want, input string name);
    int cnt = 0;
    repeat (256) begin
      if (p_audio) cnt++;
      step();
    end
    vectors++;
    if (cnt != want) begin
      miscompares++;
      $display("FAIL %s: high=%0d of 256, want %0d", name, cnt, want);
    end
  endtask

  task automatic test_pwm();
    bit found = 1'b0;
    p_wave = 1'b1;
    p_strum = 1'b1;
    step();
    p_strum = 1'b0;
    repeat (600) step();
    vectors++;
    if (p_level !== 8'd64) begin
      miscompares++;
      $display("FAIL pwm_level64: level=%0d, want 64", p_level);
    end
    repeat (10) step();
    count_pwm(64, "pwm_duty64");
    p_wave = 1'b0;
    step();
    count_pwm(0, "pwm_wave0");
    p_wave = 1'b1;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (p_level === 8'd255) found = 1'b1;
      else step();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL pwm_wait255: level=%0d never reached 255", p_level);
    end
    repeat (10) step();
    count_pwm(255, "pwm_duty255");
  endtask

  task automatic test_reset_mid();
    wave_in = 1'b1;
    strum_pulse();
    repeat (5) step();
    vectors++;
    if (level !== 8'd64 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: level=%0d busy=%b, want 64/1", level, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (level !== 8'd0 || busy !== 1'b0 || audio_out !== 1'b0 || u_dut.state !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_async: level=%0d busy=%b audio=%b, want 0/0/0", level, busy, audio_out);
    end
    step();
    rst_n = 1'b1;
    repeat (3) step();
    vectors++;
    if (level !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_idle: level=%0d busy=%b, want 0/0", level, busy);
    end
    strum_pulse();
    repeat (3) step();
    vectors++;
    if (level !== 8'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_restart_hold: level=%0d busy=%b, want 0/1", level, busy);
    end
    step();
    vectors++;
    if (level !== 8'd64) begin
      miscompares++;
      $display("FAIL rst_restart: level=%0d, want 64", level);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_attack();
    test_decay();
    test_retrigger();
    test_mute();
    test_pwm();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
